// File: rtl/fp_accum_pkg.sv
// Shared types for the fp16-into-fp32 accumulate scheduler.
package fp_accum_pkg;

  typedef logic [15:0] fp16_t;
  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_ZERO = 32'h0000_0000;
  localparam fp16_t FP16_ZERO = 16'h0000;

  // Wide enough for any accumulator bank this block is built with.
  localparam int MAX_IDX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } inflight_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the rotating pointer,
// pointer moves past the winner only when a grant is actually made.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_sel;
  logic [PW-1:0] w_next_ptr;
  logic          w_take;

  // Lowest requester overall, overridden by the lowest one at or above the pointer.
  always_comb begin
    w_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_sel = req_i[i] ? PW'(i) : w_sel;
    end
    for (int i = N - 1; i >= 0; i--) begin
      w_sel = (req_i[i] && (i >= int'(r_ptr))) ? PW'(i) : w_sel;
    end
  end

  assign w_take     = en_i & (|req_i);
  assign w_next_ptr = (w_sel == PW'(N - 1)) ? '0 : (w_sel + PW'(1));
  assign gnt_o      = w_take ? (N'(1) << w_sel) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_take) begin
      r_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/fp_accum_scheduler.sv
// Arbitrates fp16 addends from several requesters onto one shared fp32 adder
// and keeps the fp32 accumulator bank, blocking reuse of an index until its sum returns.
module fp_accum_scheduler
  import fp_accum_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_ACC   = 16,
  parameter int ADDER_LAT = 3,
  parameter int IDX_W     = $clog2(NUM_ACC)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*16-1:0]    req_data_i,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx_i,
  input  logic                     clr_valid_i,
  input  logic [IDX_W-1:0]         clr_idx_i,
  output logic                     clr_ready_o,
  output logic [15:0]              add_fp16_o,
  output logic [31:0]              add_fp32_o,
  input  logic [31:0]              add_result_i,
  input  logic [IDX_W-1:0]         rd_idx_i,
  output logic [31:0]              rd_data_o,
  output logic                     rd_busy_o,
  output logic                     idle_o
);

  fp32_t              r_acc [NUM_ACC];
  logic [NUM_ACC-1:0] r_busy;
  // Stage 0 lines up with the operand cycle, so the last stage meets the adder output.
  inflight_t          r_pipe [ADDER_LAT+1];
  fp16_t              r_fp16;
  fp32_t              r_fp32;

  logic               w_clr_acc;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_ridx;
  fp16_t              w_sel_data;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_issue;
  inflight_t          w_push;
  logic               w_head_v;
  logic [IDX_W-1:0]   w_wb_idx;
  logic [NUM_ACC-1:0] w_wb_mask;
  logic [NUM_ACC-1:0] w_iss_mask;
  logic               w_inflight;

  assign w_clr_acc = clr_valid_i & ~r_busy[clr_idx_i];

  // A clear wins over a request to the same accumulator in the same cycle.
  always_comb begin
    w_elig = '0;
    w_ridx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ridx    = req_idx_i[i*IDX_W +: IDX_W];
      w_elig[i] = req_valid_i[i] & ~r_busy[w_ridx] & ~(w_clr_acc & (clr_idx_i == w_ridx));
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (w_elig),
    .en_i  (1'b1),
    .gnt_o (w_gnt)
  );

  always_comb begin
    w_sel_data = FP16_ZERO;
    w_sel_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_data = w_gnt[i] ? req_data_i[i*16 +: 16] : w_sel_data;
      w_sel_idx  = w_gnt[i] ? req_idx_i[i*IDX_W +: IDX_W] : w_sel_idx;
    end
  end

  assign w_issue     = |w_gnt;
  assign w_push      = '{valid: w_issue, idx: MAX_IDX_W'(w_sel_idx)};
  assign w_head_v    = r_pipe[ADDER_LAT].valid;
  assign w_wb_idx    = IDX_W'(r_pipe[ADDER_LAT].idx);
  assign w_wb_mask   = w_head_v ? (NUM_ACC'(1) << w_wb_idx) : '0;
  assign w_iss_mask  = w_issue ? (NUM_ACC'(1) << w_sel_idx) : '0;

  always_comb begin
    w_inflight = 1'b0;
    for (int k = 0; k <= ADDER_LAT; k++) begin
      w_inflight = w_inflight | r_pipe[k].valid;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k <= ADDER_LAT; k++) begin
        r_pipe[k] <= '0;
      end
    end else begin
      r_pipe[0] <= w_push;
      for (int k = 1; k <= ADDER_LAT; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  // Operands hold between issues; the datapath result is only consumed when tagged valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fp16 <= FP16_ZERO;
      r_fp32 <= FP32_ZERO;
    end else if (w_issue) begin
      r_fp16 <= w_sel_data;
      r_fp32 <= r_acc[w_sel_idx];
    end
  end

  // Writeback and clear never target the same index: a busy index refuses clears.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int a = 0; a < NUM_ACC; a++) begin
        r_acc[a] <= FP32_ZERO;
      end
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_wb_mask) | w_iss_mask;
      if (w_head_v) begin
        r_acc[w_wb_idx] <= add_result_i;
      end
      if (w_clr_acc) begin
        r_acc[clr_idx_i] <= FP32_ZERO;
      end
    end
  end

  assign req_ready_o = w_gnt;
  assign clr_ready_o = w_clr_acc;
  assign add_fp16_o  = r_fp16;
  assign add_fp32_o  = r_fp32;
  assign rd_data_o   = r_acc[rd_idx_i];
  assign rd_busy_o   = r_busy[rd_idx_i];
  assign idle_o      = ~w_inflight;

endmodule
